// File: rtl/dma_wb8_pkg.sv
// Shared definitions for the dma_wb8 DMA engine: register offsets, CTRL/STATUS
// bit positions, FSM state encoding and byte-lane helpers.
package dma_wb8_pkg;

  localparam logic [3:0] REG_LEN_LO = 4'h8;
  localparam logic [3:0] REG_LEN_HI = 4'h9;
  localparam logic [3:0] REG_CTRL   = 4'hA;

  localparam int CTRL_START    = 0;
  localparam int CTRL_IE       = 1;
  localparam int CTRL_ABORT    = 2;
  localparam int CTRL_DONE_CLR = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_IE      = 1;
  localparam int STAT_DONE    = 2;
  localparam int STAT_ABORTED = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_NEXT    = 3'd5
  } state_e;

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = word;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dma_wb8_if.sv
// Bus bundle for dma_wb8: the 8-bit register responder port and the 8-bit
// Wishbone initiator port. The master modport is the DMA engine's view.
interface dma_wb8_if;
  // Handshake: stb is "valid" on both ports. Responder side: O_wb_ack is stb
  // delayed one cycle. Initiator side: a strobe is taken ("ready") in any cycle
  // with I_m_stall low; I_m_ack later marks the data phase (read data valid).
  logic [3:0]  I_wb_adr;
  logic [7:0]  I_wb_dat;
  logic        I_wb_stb;
  logic        I_wb_we;
  logic [7:0]  O_wb_dat;
  logic        O_wb_ack;
  logic        O_m_cyc;
  logic        O_m_stb;
  logic        O_m_we;
  logic [31:0] O_m_adr;
  logic [7:0]  O_m_dat;
  logic [7:0]  I_m_dat;
  logic        I_m_ack;
  logic        I_m_stall;

  modport master (
    input  I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we, I_m_dat, I_m_ack, I_m_stall,
    output O_wb_dat, O_wb_ack, O_m_cyc, O_m_stb, O_m_we, O_m_adr, O_m_dat
  );

  modport slave (
    output I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we, I_m_dat, I_m_ack, I_m_stall,
    input  O_wb_dat, O_wb_ack, O_m_cyc, O_m_stb, O_m_we, O_m_adr, O_m_dat
  );
endinterface

// File: rtl/dma_wb8_master.sv
// dma_wb8 copy engine: FSM, Wishbone initiator and the SRC/DST/LEN counters.
// Counters are CPU-writable only while idle.
module dma_wb8_master
  import dma_wb8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        reg_wr,
  input  logic [3:0]  reg_adr,
  input  logic [7:0]  reg_dat,
  output logic [31:0] src,
  output logic [31:0] dst,
  output logic [15:0] len,
  output logic        busy,
  output logic        finish,
  output logic        finish_aborted,
  output state_e      state,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [31:0] m_adr,
  output logic [7:0]  m_dat,
  input  logic [7:0]  m_dat_i,
  input  logic        m_ack,
  input  logic        m_stall
);

  state_e      state_n;
  logic [7:0]  rbuf;
  logic        abort_pend;
  logic [15:0] len_dec;
  logic        stop;

  // A zero-length start passes through NEXT, so LEN must saturate at 0 there.
  assign len_dec = (len == 16'd0) ? 16'd0 : len - 16'd1;
  assign stop    = (len_dec == 16'd0) || abort_pend || abort;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (start) state_n = (len == 16'd0) ? ST_NEXT : ST_RD_REQ;
      ST_RD_REQ:  if (!m_stall) state_n = ST_RD_WAIT;
      ST_RD_WAIT: if (m_ack) state_n = ST_WR_REQ;
      ST_WR_REQ:  if (!m_stall) state_n = ST_WR_WAIT;
      ST_WR_WAIT: if (m_ack) state_n = ST_NEXT;
      ST_NEXT:    state_n = stop ? ST_IDLE : ST_RD_REQ;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    m_cyc          = 1'b0;
    m_stb          = 1'b0;
    m_we           = 1'b0;
    m_adr          = 32'h0;
    m_dat          = 8'h00;
    finish         = 1'b0;
    finish_aborted = 1'b0;
    case (state)
      ST_RD_REQ:  begin m_cyc = 1'b1; m_stb = 1'b1; m_adr = src; end
      ST_RD_WAIT: begin m_cyc = 1'b1; m_adr = src; end
      ST_WR_REQ:  begin m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = dst; m_dat = rbuf; end
      ST_WR_WAIT: begin m_cyc = 1'b1; m_we = 1'b1; m_adr = dst; m_dat = rbuf; end
      ST_NEXT: begin
        finish         = stop;
        finish_aborted = stop & (abort_pend | abort);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src        <= 32'h0;
      dst        <= 32'h0;
      len        <= 16'h0;
      rbuf       <= 8'h00;
      abort_pend <= 1'b0;
    end else begin
      if (reg_wr && state == ST_IDLE) begin
        case (reg_adr[3:2])
          2'd0: src <= put_byte(src, reg_adr[1:0], reg_dat);
          2'd1: dst <= put_byte(dst, reg_adr[1:0], reg_dat);
          2'd2: begin
            if (reg_adr == REG_LEN_LO)      len[7:0]  <= reg_dat;
            else if (reg_adr == REG_LEN_HI) len[15:8] <= reg_dat;
          end
          default: ;
        endcase
      end
      if (state == ST_RD_WAIT && m_ack) rbuf <= m_dat_i;
      if (state == ST_NEXT && len != 16'd0) begin
        src <= src + 32'd1;
        dst <= dst + 32'd1;
        len <= len_dec;
      end
      if (state == ST_IDLE) abort_pend <= 1'b0;
      else if (abort)       abort_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/dma_wb8.sv
// dma_wb8 top: 8-bit register front-end plus the dma_wb8_master copy engine.
// Define DMA_WB8_IRQ_EN to build the IE bit and the O_interrupt logic.
module dma_wb8
  import dma_wb8_pkg::*;
#(
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic      I_wb_clk,
  input  logic      I_reset,
  dma_wb8_if.master bus,
  output logic      O_interrupt,
  output state_e    dbg_state
);

  logic [31:0] src, dst;
  logic [15:0] len;
  logic        busy, finish, finish_aborted;
  logic        reg_wr, ctrl_wr, start_pulse, abort_pulse, done_clr;
  logic        done_q, aborted_q, ie;
  logic [7:0]  status, rd_mux;

  assign reg_wr      = bus.I_wb_stb & bus.I_wb_we;
  assign ctrl_wr     = reg_wr & (bus.I_wb_adr == REG_CTRL);
  // START and ABORT in one write resolve by the current busy state.
  assign start_pulse = ctrl_wr & bus.I_wb_dat[CTRL_START] & ~busy;
  assign abort_pulse = ctrl_wr & bus.I_wb_dat[CTRL_ABORT] & busy;
  assign done_clr    = ctrl_wr & bus.I_wb_dat[CTRL_DONE_CLR];
  assign status      = {4'b0000, aborted_q, done_q, ie, busy};

  always_comb begin
    rd_mux = 8'h00;
    case (bus.I_wb_adr)
      4'h0, 4'h1, 4'h2, 4'h3: rd_mux = get_byte(src, bus.I_wb_adr[1:0]);
      4'h4, 4'h5, 4'h6, 4'h7: rd_mux = get_byte(dst, bus.I_wb_adr[1:0]);
      REG_LEN_LO:             rd_mux = len[7:0];
      REG_LEN_HI:             rd_mux = len[15:8];
      REG_CTRL:               rd_mux = status;
      default:                rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      bus.O_wb_ack <= 1'b0;
      bus.O_wb_dat <= 8'h00;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      bus.O_wb_ack <= bus.I_wb_stb;
      if (bus.I_wb_stb && !bus.I_wb_we) bus.O_wb_dat <= rd_mux;
      if (finish)                                              done_q <= 1'b1;
      else if (done_clr || (start_pulse && CLEAR_ON_START))    done_q <= 1'b0;
      if (start_pulse)                   aborted_q <= 1'b0;
      else if (finish && finish_aborted) aborted_q <= 1'b1;
    end
  end

`ifdef DMA_WB8_IRQ_EN
  logic irq_q;
  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      ie    <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= bus.I_wb_dat[CTRL_IE];
      irq_q <= done_q & ie;
    end
  end
  assign O_interrupt = irq_q;
`else
  assign ie          = 1'b0;
  assign O_interrupt = 1'b0;
`endif

  dma_wb8_master u_master (
    .clk            (I_wb_clk),
    .rst            (I_reset),
    .start          (start_pulse),
    .abort          (abort_pulse),
    .reg_wr         (reg_wr),
    .reg_adr        (bus.I_wb_adr),
    .reg_dat        (bus.I_wb_dat),
    .src            (src),
    .dst            (dst),
    .len            (len),
    .busy           (busy),
    .finish         (finish),
    .finish_aborted (finish_aborted),
    .state          (dbg_state),
    .m_cyc          (bus.O_m_cyc),
    .m_stb          (bus.O_m_stb),
    .m_we           (bus.O_m_we),
    .m_adr          (bus.O_m_adr),
    .m_dat          (bus.O_m_dat),
    .m_dat_i        (bus.I_m_dat),
    .m_ack          (bus.I_m_ack),
    .m_stall        (bus.I_m_stall)
  );

endmodule
